// File: rtl/div32_seq_pkg.sv
// Shared constants for the sequential divider: state encoding, step count,
// the divide-by-zero quotient and a small negation helper.
package div32_seq_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] ITER = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam int          DIV_ITERS     = 32;
    localparam logic [4:0]  ITER_LAST     = 5'(DIV_ITERS - 1);
    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    // Two's-complement negate by the carry-free rule: bits above the lowest
    // set bit invert, bits up to and including it pass through.
    function automatic logic [31:0] neg32_scan(input logic [31:0] x);
        logic [31:0] y;
        logic        seen;
        y    = '0;
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            y[i] = x[i] ^ seen;
            seen = seen | x[i];
        end
        return y;
    endfunction

endpackage

// File: rtl/div32_seq_add32.sv
// 32-bit adder with carry in/out; the divider uses it in subtract mode by
// feeding an inverted operand and cin=1.
module add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

// File: rtl/div32_seq.sv
// Restoring 32-bit divider, one quotient bit per clock, quotient on LO and
// remainder on HI, start/done handshake.
module div32_seq
    import div32_seq_pkg::*;
#(
    parameter logic SIGNED = 1'b1
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        start,
    input  logic [31:0] Ra,
    input  logic [31:0] Rb,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    logic [2:0]  state_q, state_d;
    logic [31:0] r_q, r_d;
    logic [31:0] q_q, q_d;
    logic [31:0] d_q, d_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q_q, neg_q_d;
    logic        neg_r_q, neg_r_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        dbz_q, dbz_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [31:0] add_a, add_b, add_sum, neg_src, r_shift;
    logic        add_cin, add_cout, take;

    add32 u_add32 (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        take        = 1'b0;

        r_shift = {r_q[30:0], q_q[31]};
        // The divisor magnitude is formed while idle so PREP only has to
        // negate the dividend, keeping one adder for every negation step.
        neg_src = (state_q == IDLE) ? Rb : q_q;
        add_a   = '0;
        add_b   = ~neg_src;
        add_cin = 1'b1;
        if (state_q == ITER) begin
            add_a = r_shift;
            add_b = ~d_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d     = Ra;
                    d_d     = (SIGNED && Rb[31]) ? add_sum : Rb;
                    neg_q_d = SIGNED & (Ra[31] ^ Rb[31]);
                    neg_r_d = SIGNED & Ra[31];
                    state_d = PREP;
                end
            end
            PREP: begin
                if (d_q == '0) begin
                    quotient_d  = DIV0_QUOTIENT;
                    remainder_d = q_q;
                    dbz_d       = 1'b1;
                    state_d     = DONE;
                end else begin
                    r_d     = '0;
                    q_d     = (SIGNED && q_q[31]) ? add_sum : q_q;
                    cnt_d   = ITER_LAST;
                    state_d = ITER;
                end
            end
            ITER: begin
                take = r_q[31] | add_cout;
                r_d  = take ? add_sum : r_shift;
                q_d  = {q_q[30:0], take};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            FIX: begin
                // Quotient goes through the adder; the remainder uses the
                // scan negate so both signs are fixed on the same edge.
                quotient_d  = neg_q_q ? add_sum : q_q;
                remainder_d = neg_r_q ? neg32_scan(r_q) : r_q;
                dbz_d       = 1'b0;
                state_d     = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == PREP) || (state_d == ITER) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// Bench for div32_seq: a signed and an unsigned instance run in lockstep on
// the same operands and are compared against a plain-arithmetic model.
module tb_div32_seq;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        start;
    logic [31:0] Ra, Rb;

    logic        busy_s, done_s, dbz_s;
    logic [31:0] q_s, r_s;
    logic        busy_u, done_u, dbz_u;
    logic [31:0] q_u, r_u;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    always #5 clock = ~clock;

    div32_seq #(.SIGNED(1'b1)) dut_s (
        .clock       (clock),
        .clear_n     (clear_n),
        .start       (start),
        .Ra          (Ra),
        .Rb          (Rb),
        .busy        (busy_s),
        .done        (done_s),
        .quotient    (q_s),
        .remainder   (r_s),
        .div_by_zero (dbz_s)
    );

    div32_seq #(.SIGNED(1'b0)) dut_u (
        .clock       (clock),
        .clear_n     (clear_n),
        .start       (start),
        .Ra          (Ra),
        .Rb          (Rb),
        .busy        (busy_u),
        .done        (done_u),
        .quotient    (q_u),
        .remainder   (r_u),
        .div_by_zero (dbz_u)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural model: language division on wide integers.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                    output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            z = 1'b0;
        end
    endfunction

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [31:0] eq_s, er_s, eq_u, er_u;
        logic        ez_s, ez_u;
        int          n;
        ref_div(a, b, 1'b1, eq_s, er_s, ez_s);
        ref_div(a, b, 1'b0, eq_u, er_u, ez_u);
        @(negedge clock);
        Ra = a;
        Rb = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check_eq("busy_after_accept", 32'({busy_s, busy_u}), 32'd3);
        n = 0;
        while (n < 60) begin
            @(posedge clock);
            #1;
            n++;
            start = poke && (n == 10);
            if (done_s) break;
        end
        start = 1'b0;
        check_eq("done_seen", 32'({done_s, done_u}), 32'd3);
        check_eq("latency", n, (b == 32'd0) ? 32'd1 : 32'd34);
        check_eq("busy_in_done", 32'({busy_s, busy_u}), 32'd0);
        check_eq("quot_s", q_s, eq_s);
        check_eq("rem_s", r_s, er_s);
        check_eq("dbz_s", 32'(dbz_s), 32'(ez_s));
        check_eq("quot_u", q_u, eq_u);
        check_eq("rem_u", r_u, er_u);
        check_eq("dbz_u", 32'(dbz_u), 32'(ez_u));
        $display("txn %0d a=%h b=%h s:q=%h r=%h z=%0d u:q=%h r=%h z=%0d lat=%0d",
                 n_txn, a, b, q_s, r_s, dbz_s, q_u, r_u, dbz_u, n);
        n_txn++;
        @(posedge clock);
        #1;
        check_eq("done_width", 32'({done_s, done_u}), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        clear_n = 1'b0;
        start   = 1'b0;
        Ra      = '0;
        Rb      = '0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("reset_ctl", 32'({busy_s, done_s, dbz_s, busy_u, done_u, dbz_u}), 32'd0);
        check_eq("reset_q", q_s | q_u, 32'd0);
        check_eq("reset_r", r_s | r_u, 32'd0);
        @(negedge clock);
        clear_n = 1'b1;

        do_div(32'd100, 32'd7, 1'b0);
        check_eq("100/7 q", q_s, 32'd14);
        check_eq("100/7 r", r_s, 32'd2);
        do_div(32'hFFFF_FF9C, 32'd7, 1'b0);
        check_eq("-100/7 q", q_s, 32'hFFFF_FFF2);
        check_eq("-100/7 r", r_s, 32'hFFFF_FFFE);
        do_div(32'd100, 32'hFFFF_FFF9, 1'b0);
        check_eq("100/-7 q", q_s, 32'hFFFF_FFF2);
        check_eq("100/-7 r", r_s, 32'd2);
        do_div(32'd100, 32'd0, 1'b0);
        check_eq("div0 flag", 32'(dbz_s), 32'd1);
        check_eq("div0 q", q_s, 32'hFFFF_FFFF);
        check_eq("div0 r", r_s, 32'd100);
        do_div(32'd9, 32'd3, 1'b0);
        check_eq("div0 cleared", 32'({dbz_s, dbz_u}), 32'd0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_eq("min/-1 q", q_s, 32'h8000_0000);
        check_eq("min/-1 r", r_s, 32'd0);
        check_eq("min/-1 flag", 32'(dbz_s), 32'd0);
        do_div(32'hFFFF_FFFF, 32'h10, 1'b0);
        check_eq("u ffffffff/16 q", q_u, 32'h0FFF_FFFF);
        check_eq("u ffffffff/16 r", r_u, 32'hF);

        // A second start mid-iteration must be ignored.
        do_div(32'd1000, 32'd33, 1'b1);

        // Asynchronous reset in the middle of a division.
        @(negedge clock);
        Ra = 32'd1234567;
        Rb = 32'd89;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        #2;
        clear_n = 1'b0;
        #1;
        check_eq("midreset_ctl", 32'({busy_s, done_s, dbz_s, busy_u, done_u, dbz_u}), 32'd0);
        check_eq("midreset_q", q_s | q_u, 32'd0);
        check_eq("midreset_r", r_s | r_u, 32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        do_div(32'd50, 32'd5, 1'b0);
        check_eq("50/5 q", q_s, 32'd10);
        check_eq("50/5 r", r_s, 32'd0);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, b;
            a = pick();
            b = pick();
            do_div(a, b, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
